// File: rtl/exc_commit_ctrl.sv
// rtl/exc_commit_ctrl.sv - commit-point exception/ERTN controller between WB and csr
// Takes prioritised WB exceptions or ertn, pulses csr, flushes and offers a redirect PC to fetch.
module exc_commit_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int FLUSH_HOLD = 2,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_pc,
  input  logic [ADDR_W-1:0] wb_vaddr,
  input  logic              wb_exc_adef,
  input  logic              wb_exc_ine,
  input  logic              wb_exc_sys,
  input  logic              wb_exc_brk,
  input  logic              wb_exc_ale,
  input  logic              wb_is_ertn,
  input  logic              interrupt,
  input  logic [ADDR_W-1:0] exception_entry,
  input  logic [ADDR_W-1:0] exception_return_entry,
  output logic              csr_exception,
  output logic              csr_ertn_flush,
  output logic [5:0]        csr_ecode,
  output logic [8:0]        csr_esubcode,
  output logic [ADDR_W-1:0] csr_vaddr,
  output logic [ADDR_W-1:0] csr_pc,
  output logic              wb_commit,
  output logic              flush_all,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              redirect_ready,
  output logic [CNT_W-1:0]  exc_count
);

  localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(FLUSH_HOLD - 1);

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_ALE  = 6'h09;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]    exc_count_q, exc_count_d;

  logic exc_any;
  logic take;
  logic event_exc;
  logic event_ertn;

  assign exc_any    = wb_exc_adef | wb_exc_ine | wb_exc_sys | wb_exc_brk | wb_exc_ale;
  // WB inputs only matter in IDLE; an interrupt waits until an instruction is present.
  assign take       = (state_q == IDLE) & wb_valid;
  assign event_exc  = take & (interrupt | exc_any);
  assign event_ertn = take & wb_is_ertn & ~(interrupt | exc_any);

  always_comb begin
    csr_ecode = 6'h00;
    if (event_exc) begin
      if (interrupt)        csr_ecode = ECODE_INT;
      else if (wb_exc_adef) csr_ecode = ECODE_ADEF;
      else if (wb_exc_ine)  csr_ecode = ECODE_INE;
      else if (wb_exc_sys)  csr_ecode = ECODE_SYS;
      else if (wb_exc_brk)  csr_ecode = ECODE_BRK;
      else                  csr_ecode = ECODE_ALE;
    end
  end

  assign csr_exception  = event_exc;
  assign csr_ertn_flush = event_ertn;
  assign csr_esubcode   = 9'h000;
  assign csr_vaddr      = take ? (wb_exc_adef ? wb_pc : wb_vaddr) : '0;
  assign csr_pc         = take ? wb_pc : '0;
  assign wb_commit      = take & ~(interrupt | exc_any);
  assign flush_all      = event_exc | event_ertn | (state_q == REDIRECT);
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = redirect_pc_q;
  assign exc_count      = exc_count_q;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    redirect_pc_d = redirect_pc_q;
    exc_count_d   = exc_count_q;
    case (state_q)
      IDLE: begin
        if (event_exc | event_ertn) begin
          state_d       = REDIRECT;
          hold_d        = HOLD_INIT;
          redirect_pc_d = event_exc ? exception_entry : exception_return_entry;
          if (event_exc) exc_count_d = exc_count_q + CNT_W'(1);
        end
      end
      REDIRECT: begin
        if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
        // redirect_pc stays put until fetch takes it and the flush window has elapsed.
        if (redirect_ready && (hold_q == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      redirect_pc_q <= '0;
      exc_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      redirect_pc_q <= redirect_pc_d;
      exc_count_q   <= exc_count_d;
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// tb/tb_exc_commit_ctrl.sv - directed self-checking bench for exc_commit_ctrl
module tb_exc_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [31:0] wb_pc, wb_vaddr;
  logic        wb_exc_adef, wb_exc_ine, wb_exc_sys, wb_exc_brk, wb_exc_ale;
  logic        wb_is_ertn, interrupt;
  logic [31:0] exception_entry, exception_return_entry;
  logic        csr_exception, csr_ertn_flush;
  logic [5:0]  csr_ecode;
  logic [8:0]  csr_esubcode;
  logic [31:0] csr_vaddr, csr_pc;
  logic        wb_commit, flush_all, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic [31:0] exc_count;

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  exc_commit_ctrl #(.ADDR_W(32), .FLUSH_HOLD(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .wb_exc_adef(wb_exc_adef), .wb_exc_ine(wb_exc_ine), .wb_exc_sys(wb_exc_sys),
    .wb_exc_brk(wb_exc_brk), .wb_exc_ale(wb_exc_ale),
    .wb_is_ertn(wb_is_ertn), .interrupt(interrupt),
    .exception_entry(exception_entry), .exception_return_entry(exception_return_entry),
    .csr_exception(csr_exception), .csr_ertn_flush(csr_ertn_flush),
    .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
    .csr_vaddr(csr_vaddr), .csr_pc(csr_pc),
    .wb_commit(wb_commit), .flush_all(flush_all),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .exc_count(exc_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // flags = {adef, ine, sys, brk, ale}
  task automatic set_wb(input logic v, input logic [31:0] pc, input logic [31:0] va,
                        input logic [4:0] flags, input logic ertn, input logic intr);
    wb_valid    = v;
    wb_pc       = pc;
    wb_vaddr    = va;
    wb_exc_adef = flags[4];
    wb_exc_ine  = flags[3];
    wb_exc_sys  = flags[2];
    wb_exc_brk  = flags[1];
    wb_exc_ale  = flags[0];
    wb_is_ertn  = ertn;
    interrupt   = intr;
  endtask

  task automatic clr;
    set_wb(1'b0, 32'h0, 32'h0, 5'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    redirect_ready = 1'b1;
    @(negedge clk);
    while (redirect_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(redirect_valid), 64'h0);
    step;
  endtask

  task automatic take_exc(input string tag, input logic [31:0] pc, input logic [31:0] va,
                          input logic [4:0] flags, input logic ertn, input logic intr,
                          input logic [5:0] ecode, input logic [31:0] vaddr);
    set_wb(1'b1, pc, va, flags, ertn, intr);
    @(negedge clk);
    chk({tag, "_exc"}, 64'(csr_exception), 64'h1);
    chk({tag, "_ertn"}, 64'(csr_ertn_flush), 64'h0);
    chk({tag, "_commit"}, 64'(wb_commit), 64'h0);
    chk({tag, "_ecode"}, 64'(csr_ecode), 64'(ecode));
    chk({tag, "_vaddr"}, 64'(csr_vaddr), 64'(vaddr));
    chk({tag, "_pc"}, 64'(csr_pc), 64'(pc));
    step;
    clr;
    exp_cnt++;
    chk({tag, "_rpc"}, 64'(redirect_pc), 64'(exception_entry));
    wait_idle;
    chk({tag, "_cnt"}, 64'(exc_count), 64'(exp_cnt));
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_ready = 1'b1;
    exception_entry = 32'h1c008000;
    exception_return_entry = 32'h1c000200;
    clr;
    repeat (2) step;
    @(negedge clk);
    chk("rst_exc", 64'(csr_exception), 64'h0);
    chk("rst_flush", 64'(flush_all), 64'h0);
    chk("rst_rv", 64'(redirect_valid), 64'h0);
    chk("rst_rpc", 64'(redirect_pc), 64'h0);
    chk("rst_cnt", 64'(exc_count), 64'h0);
    step;
    rst_n = 1'b1;

    // SYS with cycle-by-cycle redirect timing
    set_wb(1'b1, 32'h1c000100, 32'h0, 5'b00100, 1'b0, 1'b0);
    @(negedge clk);
    chk("sys_exc", 64'(csr_exception), 64'h1);
    chk("sys_ecode", 64'(csr_ecode), 64'h0B);
    chk("sys_esub", 64'(csr_esubcode), 64'h0);
    chk("sys_flush", 64'(flush_all), 64'h1);
    chk("sys_commit", 64'(wb_commit), 64'h0);
    chk("sys_pc", 64'(csr_pc), 64'h1c000100);
    step;
    @(negedge clk);
    chk("sys_n1_rv", 64'(redirect_valid), 64'h1);
    chk("sys_n1_rpc", 64'(redirect_pc), 64'h1c008000);
    chk("sys_n1_ignored", 64'(csr_exception), 64'h0);
    chk("sys_n1_flush", 64'(flush_all), 64'h1);
    chk("sys_n1_cnt", 64'(exc_count), 64'h1);
    step;
    clr;
    @(negedge clk);
    chk("sys_n2_hold_rv", 64'(redirect_valid), 64'h1);
    step;
    @(negedge clk);
    chk("sys_n3_rv", 64'(redirect_valid), 64'h0);
    chk("sys_n3_flush", 64'(flush_all), 64'h0);
    step;
    exp_cnt = 1;

    take_exc("int_all", 32'h1c000003, 32'h00008001, 5'b10001, 1'b0, 1'b1, 6'h00, 32'h1c000003);
    take_exc("adef_ale", 32'h1c000040, 32'h00008001, 5'b10001, 1'b0, 1'b0, 6'h08, 32'h1c000040);
    take_exc("ale", 32'h1c000044, 32'h00008001, 5'b00001, 1'b0, 1'b0, 6'h09, 32'h00008001);
    take_exc("ine_sys_brk", 32'h1c000048, 32'h0, 5'b01110, 1'b0, 1'b0, 6'h0D, 32'h0);
    take_exc("brk_ertn", 32'h1c00004c, 32'h0, 5'b00010, 1'b1, 1'b0, 6'h0C, 32'h0);

    // ertn with fetch stalling the redirect
    redirect_ready = 1'b0;
    set_wb(1'b1, 32'h1c000180, 32'h0, 5'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("ertn_flush_pulse", 64'(csr_ertn_flush), 64'h1);
    chk("ertn_commit", 64'(wb_commit), 64'h1);
    chk("ertn_exc", 64'(csr_exception), 64'h0);
    chk("ertn_flush_all", 64'(flush_all), 64'h1);
    step;
    clr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ertn_stall_rv", 64'(redirect_valid), 64'h1);
      chk("ertn_stall_rpc", 64'(redirect_pc), 64'h1c000200);
      chk("ertn_stall_pulse", 64'(csr_ertn_flush), 64'h0);
      step;
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    chk("ertn_accept_rv", 64'(redirect_valid), 64'h1);
    step;
    @(negedge clk);
    chk("ertn_done_rv", 64'(redirect_valid), 64'h0);
    chk("ertn_cnt", 64'(exc_count), 64'(exp_cnt));
    step;

    // interrupt waits for a valid WB instruction
    interrupt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("int_wait_exc", 64'(csr_exception), 64'h0);
      chk("int_wait_flush", 64'(flush_all), 64'h0);
      step;
    end
    take_exc("int_take", 32'h1c000300, 32'h0, 5'b0, 1'b0, 1'b1, 6'h00, 32'h0);

    // reset while a redirect is pending
    set_wb(1'b1, 32'h1c000400, 32'h0, 5'b00100, 1'b0, 1'b0);
    step;
    clr;
    @(negedge clk);
    chk("rst_mid_rv_before", 64'(redirect_valid), 64'h1);
    rst_n = 1'b0;
    step;
    chk("rst_mid_rv", 64'(redirect_valid), 64'h0);
    chk("rst_mid_flush", 64'(flush_all), 64'h0);
    chk("rst_mid_cnt", 64'(exc_count), 64'h0);
    rst_n = 1'b1;
    step;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
